// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Shares the register bank's single write port among NREQ writeback
//   sources (0=ALU, 1=load unit, 2=link/PC+4). One source is granted per
//   cycle in round-robin order. The granted write is captured into a
//   one-entry stage that drives the bank write port on the following cycle.
//   The staged address is also exported so decode can stall on RAW hazards.
//
// Parameters
//   NREQ     number of writeback requesters (2..4)
//   AW       register address width
//   DW       register data width
//   DROP_R0  1: a granted write to address 0 is accepted but never issued
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   req_valid       [NREQ]     requester i has a write pending
//   req_addr        [NREQ*AW]  packed, requester i at [i*AW +: AW]
//   req_data        [NREQ*DW]  packed, requester i at [i*DW +: DW]
//   req_ready       [NREQ]     one-hot grant (combinational), transfer = valid & ready
//   hold            freeze arbitration for this cycle
//   regWriteEnable  bank write enable (registered)
//   regAddr_write   bank write address (registered)
//   regWriteData    bank write data (registered)
//   pend_valid      a write is staged (same as regWriteEnable)
//   pend_addr       staged write address (same as regAddr_write)
//   grant_id        index of the last granted requester
module reg_write_arbiter #(
  parameter int NREQ    = 3,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int DROP_R0 = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               hold,
  output logic               regWriteEnable,
  output logic [AW-1:0]      regAddr_write,
  output logic [DW-1:0]      regWriteData,
  output logic               pend_valid,
  output logic [AW-1:0]      pend_addr,
  output logic [1:0]         grant_id
);

  // Pointer reset value makes requester 0 the first in line.
  localparam logic [1:0] PTR_RST = 2'(NREQ - 1);

  logic [1:0]      last_ptr_r;
  logic            wen_r;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   data_r;

  logic [NREQ-1:0] ready_s;
  logic [1:0]      gnt_idx_s;
  logic [1:0]      cand_s;
  logic            found_s;
  logic            xfer_s;
  logic            drop_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_data_s;

  // Index k steps after base, wrapped modulo NREQ.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NREQ;
    return s[1:0];
  endfunction

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    ready_s   = '0;
    gnt_idx_s = last_ptr_r;
    cand_s    = last_ptr_r;
    found_s   = 1'b0;
    if (rst || hold) begin
      ready_s = '0;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        cand_s = rr_idx(last_ptr_r, k);
        if (!found_s && req_valid[cand_s]) begin
          ready_s[cand_s] = 1'b1;
          gnt_idx_s       = cand_s;
          found_s         = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Select the granted requester's address and data.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ready_s[i]) begin
        sel_addr_s = req_addr[i*AW +: AW];
        sel_data_s = req_data[i*DW +: DW];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  // A grant is only ever given to a valid requester, so any ready bit is a transfer.
  assign xfer_s = |ready_s;
  assign drop_s = (DROP_R0 != 0) && (sel_addr_s == {AW{1'b0}});

  // Write stage and round-robin pointer; reset discards any staged write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_r      <= 1'b0;
      addr_r     <= '0;
      data_r     <= '0;
      last_ptr_r <= PTR_RST;
    end else begin
      wen_r <= xfer_s & ~drop_s;
      if (xfer_s) begin
        addr_r     <= sel_addr_s;
        data_r     <= sel_data_s;
        last_ptr_r <= gnt_idx_s;
      end
    end
  end

  assign req_ready      = ready_s;
  assign regWriteEnable = wen_r;
  assign regAddr_write  = addr_r;
  assign regWriteData   = data_r;
  assign pend_valid     = wen_r;
  assign pend_addr      = addr_r;
  assign grant_id       = last_ptr_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        hold;

  logic [2:0]  ready0, ready1;
  logic        wen0, wen1, pv0, pv1;
  logic [4:0]  addr0, addr1, paddr0, paddr1;
  logic [31:0] data0, data1;
  logic [1:0]  gid0, gid1;

  int tests  = 0;
  int failed = 0;

  logic [31:0] bank [32];

  always #5 clk = ~clk;

  reg_write_arbiter #(.NREQ(3), .AW(5), .DW(32), .DROP_R0(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(ready0), .hold(hold),
    .regWriteEnable(wen0), .regAddr_write(addr0), .regWriteData(data0),
    .pend_valid(pv0), .pend_addr(paddr0), .grant_id(gid0)
  );

  reg_write_arbiter #(.NREQ(3), .AW(5), .DW(32), .DROP_R0(1)) dut_drop (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(ready1), .hold(hold),
    .regWriteEnable(wen1), .regAddr_write(addr1), .regWriteData(data1),
    .pend_valid(pv1), .pend_addr(paddr1), .grant_id(gid1)
  );

  // Register bank model fed by the DROP_R0=0 instance.
  always @(posedge clk) begin
    if (wen0) bank[addr0] <= data0;
  end

  typedef struct {
    logic [2:0]  valid;
    logic        hold;
    logic [2:0]  exp_ready;
    logic        exp_wen;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_gid;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  initial begin
    // Requester i defaults: addr 10+i, data 0xA000_000i.
    rst = 1'b1; hold = 1'b0; req_valid = 3'b111;
    req_addr = '0; req_data = '0;
    for (int i = 0; i < 3; i++) set_req(i, 5'(10 + i), 32'hA000_0000 + 32'(i));

    // Round-robin, hold, sparse-valid patterns (ptr starts at 2 after reset).
    vq.push_back('{3'b111, 1'b0, 3'b001, 1'b1, 5'd10, 32'hA000_0000, 2'd0});
    vq.push_back('{3'b111, 1'b0, 3'b010, 1'b1, 5'd11, 32'hA000_0001, 2'd1});
    vq.push_back('{3'b111, 1'b0, 3'b100, 1'b1, 5'd12, 32'hA000_0002, 2'd2});
    vq.push_back('{3'b111, 1'b0, 3'b001, 1'b1, 5'd10, 32'hA000_0000, 2'd0});
    vq.push_back('{3'b111, 1'b0, 3'b010, 1'b1, 5'd11, 32'hA000_0001, 2'd1});
    vq.push_back('{3'b111, 1'b0, 3'b100, 1'b1, 5'd12, 32'hA000_0002, 2'd2});
    vq.push_back('{3'b111, 1'b0, 3'b001, 1'b1, 5'd10, 32'hA000_0000, 2'd0});
    vq.push_back('{3'b111, 1'b1, 3'b000, 1'b0, 5'd10, 32'hA000_0000, 2'd0});
    vq.push_back('{3'b111, 1'b1, 3'b000, 1'b0, 5'd10, 32'hA000_0000, 2'd0});
    vq.push_back('{3'b111, 1'b1, 3'b000, 1'b0, 5'd10, 32'hA000_0000, 2'd0});
    vq.push_back('{3'b111, 1'b0, 3'b010, 1'b1, 5'd11, 32'hA000_0001, 2'd1});
    vq.push_back('{3'b000, 1'b0, 3'b000, 1'b0, 5'd11, 32'hA000_0001, 2'd1});
    vq.push_back('{3'b100, 1'b0, 3'b100, 1'b1, 5'd12, 32'hA000_0002, 2'd2});
    vq.push_back('{3'b010, 1'b0, 3'b010, 1'b1, 5'd11, 32'hA000_0001, 2'd1});
    vq.push_back('{3'b101, 1'b0, 3'b100, 1'b1, 5'd12, 32'hA000_0002, 2'd2});
    vq.push_back('{3'b101, 1'b0, 3'b001, 1'b1, 5'd10, 32'hA000_0000, 2'd0});
    vq.push_back('{3'b011, 1'b0, 3'b010, 1'b1, 5'd11, 32'hA000_0001, 2'd1});

    // T1: reset with all valid.
    @(negedge clk);
    check("rst_ready", 32'(ready0), 32'h0);
    check("rst_wen", 32'(wen0), 32'h0);
    check("rst_addr", 32'(addr0), 32'h0);
    check("rst_data", data0, 32'h0);
    check("rst_pend", 32'(pv0), 32'h0);
    check("rst_gid", 32'(gid0), 32'h2);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vq[n]) begin
      req_valid = vq[n].valid;
      hold      = vq[n].hold;
      @(negedge clk);
      check($sformatf("v%0d_ready", n), 32'(ready0), 32'(vq[n].exp_ready));
      @(posedge clk); #1;
      check($sformatf("v%0d_wen", n), 32'(wen0), 32'(vq[n].exp_wen));
      check($sformatf("v%0d_pend", n), 32'(pv0), 32'(vq[n].exp_wen));
      check($sformatf("v%0d_addr", n), 32'(addr0), 32'(vq[n].exp_addr));
      check($sformatf("v%0d_paddr", n), 32'(paddr0), 32'(vq[n].exp_addr));
      check($sformatf("v%0d_data", n), data0, vq[n].exp_data);
      check($sformatf("v%0d_gid", n), 32'(gid0), 32'(vq[n].exp_gid));
    end

    // T2: single requester 1 (pointer at 1).
    hold = 1'b0;
    set_req(1, 5'd7, 32'hDEADBEEF);
    req_valid = 3'b010;
    @(negedge clk);
    check("t2_ready", 32'(ready0), 32'h2);
    @(posedge clk); #1;
    check("t2_wen", 32'(wen0), 32'h1);
    check("t2_addr", 32'(addr0), 32'h7);
    check("t2_data", data0, 32'hDEADBEEF);
    req_valid = 3'b000;
    @(posedge clk); #1;
    check("t2_wen_off", 32'(wen0), 32'h0);

    // T5: collision on r5; move pointer to 2 first so req0 wins first.
    set_req(2, 5'd9, 32'h99);
    req_valid = 3'b100;
    @(posedge clk); #1;
    set_req(0, 5'd5, 32'h11);
    set_req(2, 5'd5, 32'h22);
    req_valid = 3'b101;
    @(negedge clk);
    check("t5_ready_a", 32'(ready0), 32'h1);
    @(posedge clk); #1;
    req_valid = 3'b100;
    @(negedge clk);
    check("t5_ready_b", 32'(ready0), 32'h4);
    @(posedge clk); #1;
    req_valid = 3'b000;
    @(posedge clk); #1;
    check("t5_bank_r5", bank[5], 32'h22);
    check("t5_bank_r9", bank[9], 32'h99);

    // T6: DROP_R0 instance accepts a write to r0 but never issues it.
    set_req(0, 5'd0, 32'h55);
    req_valid = 3'b001;
    @(negedge clk);
    check("t6_ready", 32'(ready1), 32'h1);
    @(posedge clk); #1;
    check("t6_drop_wen", 32'(wen1), 32'h0);
    check("t6_drop_pend", 32'(pv1), 32'h0);
    check("t6_keep_wen", 32'(wen0), 32'h1);
    check("t6_drop_gid", 32'(gid1), 32'h0);
    set_req(0, 5'd0, 32'h66);
    @(negedge clk);
    check("t6_ready2", 32'(ready0), 32'h1);
    @(posedge clk); #1;
    check("t6_staged", 32'(wen0), 32'h1);
    // Reset between grant and issue: staged 0x66 must never reach the bank.
    rst = 1'b1;
    req_valid = 3'b000;
    #1;
    check("t6_rst_wen", 32'(wen0), 32'h0);
    check("t6_rst_gid", 32'(gid0), 32'h2);
    check("t6_rst_gid_drop", 32'(gid1), 32'h2);
    req_valid = 3'b111;
    #1;
    check("t6_rst_ready", 32'(ready0), 32'h0);
    check("t6_rst_ready_drop", 32'(ready1), 32'h0);
    @(posedge clk); #1;
    check("t6_bank_r0", bank[0], 32'h55);
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_rst_ready", 32'(ready0), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
